// File: rtl/apb2mem.sv
// apb2mem: APB4 slave to native valid/ready memory master bridge.
//
// Each APB transfer becomes at most one memory transaction. The bridge
// inserts wait states (pready=0) while the memory access is in flight and
// completes the APB access phase from a dedicated response state.
//
// Parameters
//   ADDR_OFFSET     added to the word-aligned APB address (32-bit wrap)
//   TIMEOUT_CYCLES  max REQ cycles waiting for mem_ready_i; 0 = no timeout
//
// Ports
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   apb_p*_i                       APB4 slave request
//   apb_pready_o/prdata_o/pslverr_o APB4 slave response
//   mem_valid_o/addr_o/wdata_o/wstrb_o   memory request (wstrb==0 is a read)
//   mem_rdata_i, mem_ready_i       memory response
module apb2mem #(
    parameter logic [31:0] ADDR_OFFSET    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] apb_paddr_i,
    input  logic [2:0]  apb_pprot_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    input  logic [3:0]  apb_pstrb_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen in the last REQ cycle before the timeout fires.
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t      state_q;
    logic        memValid_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memWstrb_q;
    logic [31:0] prdata_q;
    logic        err_q;
    logic [31:0] timeoutCnt_q;
    logic        aborted_q;

    logic [31:0] memAddr_d;
    logic [3:0]  memWstrb_d;
    logic        setupErr;
    logic        timeoutHit;

    // Protection bits carry no meaning for this memory.
    logic unused_pprot;
    assign unused_pprot = ^apb_pprot_i;

    assign memAddr_d  = {apb_paddr_i[31:2], 2'b00} + ADDR_OFFSET;
    assign memWstrb_d = apb_pwrite_i ? apb_pstrb_i : 4'h0;

    // Unaligned accesses and writes with no byte enabled never reach memory.
    assign setupErr   = (apb_paddr_i[1:0] != 2'b00) || (apb_pwrite_i && (apb_pstrb_i == 4'h0));

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (timeoutCnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            memValid_q   <= 1'b0;
            memAddr_q    <= 32'h0;
            memWdata_q   <= 32'h0;
            memWstrb_q   <= 4'h0;
            prdata_q     <= 32'h0;
            err_q        <= 1'b0;
            timeoutCnt_q <= 32'h0;
            aborted_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (apb_psel_i && !apb_penable_i) begin
                        memAddr_q    <= memAddr_d;
                        memWdata_q   <= apb_pwdata_i;
                        memWstrb_q   <= memWstrb_d;
                        prdata_q     <= 32'h0;
                        timeoutCnt_q <= 32'h0;
                        aborted_q    <= 1'b0;
                        if (setupErr) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            memValid_q <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A master that drops psel mid-wait gets its access
                    // finished on the memory side but no APB response.
                    if (!apb_psel_i) begin
                        aborted_q <= 1'b1;
                    end
                    // Ready takes priority over a timeout firing in the same cycle.
                    if (mem_ready_i) begin
                        memValid_q <= 1'b0;
                        prdata_q   <= (memWstrb_q == 4'h0) ? mem_rdata_i : 32'h0;
                        err_q      <= 1'b0;
                        state_q    <= (aborted_q || !apb_psel_i) ? IDLE : RESP;
                    end else if (timeoutHit) begin
                        memValid_q <= 1'b0;
                        prdata_q   <= 32'h0;
                        err_q      <= 1'b1;
                        state_q    <= (aborted_q || !apb_psel_i) ? IDLE : RESP;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 32'd1;
                    end
                end
                RESP: begin
                    if (!apb_psel_i || apb_penable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_valid_o   = memValid_q;
    assign mem_addr_o    = memAddr_q;
    assign mem_wdata_o   = memWdata_q;
    assign mem_wstrb_o   = memWstrb_q;

    assign apb_pready_o  = (state_q == RESP);
    assign apb_prdata_o  = (state_q == RESP) ? prdata_q : 32'h0;
    assign apb_pslverr_o = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_apb2mem.sv
// tb_apb2mem: directed self-checking bench for apb2mem.
// Inputs are driven 1 ns after each rising edge and outputs are sampled
// there too, so every check sees the state registered at the last edge.
module tb_apb2mem;

    logic        clk;
    logic        rstN;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        memValid;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic [31:0] memRdata;
    logic        memReady;

    int testsRun  = 0;
    int failCount = 0;
    int hsCount   = 0;
    int hsBefore  = 0;

    apb2mem #(
        .ADDR_OFFSET    (32'h8000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rstN),
        .apb_paddr_i   (paddr),
        .apb_pprot_i   (pprot),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pwrite_i  (pwrite),
        .apb_pwdata_i  (pwdata),
        .apb_pstrb_i   (pstrb),
        .apb_pready_o  (pready),
        .apb_prdata_o  (prdata),
        .apb_pslverr_o (pslverr),
        .mem_valid_o   (memValid),
        .mem_addr_o    (memAddr),
        .mem_wdata_o   (memWdata),
        .mem_wstrb_o   (memWstrb),
        .mem_rdata_i   (memRdata),
        .mem_ready_i   (memReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed memory handshakes mid-cycle.
    always @(negedge clk) begin
        if (memValid && memReady) begin
            hsCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        psel    = sel;
        penable = en;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        pprot    = 3'b010;
        memRdata = 32'h0;
        memReady = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        rstN = 1'b1;

        // Reset state
        checkOutput("rst_pready", {31'h0, pready}, 32'h0);
        checkOutput("rst_pslverr", {31'h0, pslverr}, 32'h0);
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_valid", {31'h0, memValid}, 32'h0);
        checkOutput("rst_addr", memAddr, 32'h0);
        checkOutput("rst_wstrb", {28'h0, memWstrb}, 32'h0);

        // Read, ready on first REQ cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF);
        tick();
        checkOutput("rd_valid", {31'h0, memValid}, 32'h1);
        checkOutput("rd_addr", memAddr, 32'h8000_0010);
        checkOutput("rd_wstrb", {28'h0, memWstrb}, 32'h0);
        checkOutput("rd_wait_pready", {31'h0, pready}, 32'h0);
        penable  = 1'b1;
        memReady = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        tick();
        memReady = 1'b0;
        memRdata = 32'h0;
        checkOutput("rd_pready", {31'h0, pready}, 32'h1);
        checkOutput("rd_prdata", prdata, 32'hDEAD_BEEF);
        checkOutput("rd_pslverr", {31'h0, pslverr}, 32'h0);
        checkOutput("rd_valid_drop", {31'h0, memValid}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("rd_idle_pready", {31'h0, pready}, 32'h0);
        checkOutput("rd_idle_prdata", prdata, 32'h0);

        // Write, ready delayed 4 cycles
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 32'h1234_5678, 4'b0011);
        tick();
        penable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            checkOutput($sformatf("wr_valid_%0d", i), {31'h0, memValid}, 32'h1);
            checkOutput($sformatf("wr_addr_%0d", i), memAddr, 32'h8000_0004);
            checkOutput($sformatf("wr_wdata_%0d", i), memWdata, 32'h1234_5678);
            checkOutput($sformatf("wr_wstrb_%0d", i), {28'h0, memWstrb}, 32'h3);
            checkOutput($sformatf("wr_pready_%0d", i), {31'h0, pready}, 32'h0);
            memReady = (i == 5);
            tick();
        end
        memReady = 1'b0;
        checkOutput("wr_pready", {31'h0, pready}, 32'h1);
        checkOutput("wr_pslverr", {31'h0, pslverr}, 32'h0);
        checkOutput("wr_prdata", prdata, 32'h0);
        checkOutput("wr_valid_drop", {31'h0, memValid}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Timeout: 8 REQ cycles without ready
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        penable  = 1'b1;
        memRdata = 32'hA5A5_A5A5;
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("to_valid_%0d", i), {31'h0, memValid}, 32'h1);
            checkOutput($sformatf("to_pready_%0d", i), {31'h0, pready}, 32'h0);
            tick();
        end
        checkOutput("to_valid_drop", {31'h0, memValid}, 32'h0);
        checkOutput("to_pready", {31'h0, pready}, 32'h1);
        checkOutput("to_pslverr", {31'h0, pslverr}, 32'h1);
        checkOutput("to_prdata", prdata, 32'h0);
        tick();
        memRdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("to_idle_pslverr", {31'h0, pslverr}, 32'h0);

        // Error paths: unaligned read, write with no strobes
        hsBefore = hsCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3, 32'h0, 4'h0);
        tick();
        checkOutput("ua_valid", {31'h0, memValid}, 32'h0);
        checkOutput("ua_pready", {31'h0, pready}, 32'h1);
        checkOutput("ua_pslverr", {31'h0, pslverr}, 32'h1);
        penable = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("ua_idle_pready", {31'h0, pready}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h5555_5555, 4'h0);
        tick();
        checkOutput("ns_valid", {31'h0, memValid}, 32'h0);
        checkOutput("ns_pready", {31'h0, pready}, 32'h1);
        checkOutput("ns_pslverr", {31'h0, pslverr}, 32'h1);
        penable = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("err_no_handshake", hsCount - hsBefore, 32'h0);

        // Reset in the middle of REQ
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
        tick();
        checkOutput("mr_valid_before", {31'h0, memValid}, 32'h1);
        penable = 1'b1;
        rstN    = 1'b0;
        tick();
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("mr_valid_after", {31'h0, memValid}, 32'h0);
        checkOutput("mr_pready_after", {31'h0, pready}, 32'h0);
        tick();
        checkOutput("mr_pready_idle", {31'h0, pready}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        checkOutput("mr_rd_addr", memAddr, 32'h8000_0040);
        penable  = 1'b1;
        memReady = 1'b1;
        memRdata = 32'hCAFE_F00D;
        tick();
        memReady = 1'b0;
        checkOutput("mr_rd_pready", {31'h0, pready}, 32'h1);
        checkOutput("mr_rd_prdata", prdata, 32'hCAFE_F00D);
        tick();

        // Back-to-back reads, next setup right after the completing access
        hsBefore = hsCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 4'h0);
        tick();
        checkOutput("bb1_addr", memAddr, 32'h8000_0050);
        penable  = 1'b1;
        memReady = 1'b1;
        memRdata = 32'h1111_1111;
        tick();
        memReady = 1'b0;
        checkOutput("bb1_prdata", prdata, 32'h1111_1111);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h54, 32'h0, 4'h0);
        checkOutput("bb_gap_valid", {31'h0, memValid}, 32'h0);
        tick();
        checkOutput("bb2_valid", {31'h0, memValid}, 32'h1);
        checkOutput("bb2_addr", memAddr, 32'h8000_0054);
        penable  = 1'b1;
        memReady = 1'b1;
        memRdata = 32'h2222_2222;
        tick();
        memReady = 1'b0;
        checkOutput("bb2_pready", {31'h0, pready}, 32'h1);
        checkOutput("bb2_prdata", prdata, 32'h2222_2222);
        checkOutput("bb_handshakes", hsCount - hsBefore, 32'h2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // psel dropped during REQ: access finishes, no pready
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("ab_valid_held", {31'h0, memValid}, 32'h1);
        memReady = 1'b1;
        tick();
        memReady = 1'b0;
        checkOutput("ab_valid_drop", {31'h0, memValid}, 32'h0);
        checkOutput("ab_pready", {31'h0, pready}, 32'h0);
        tick();
        checkOutput("ab_pready_next", {31'h0, pready}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
